// File: rtl/player_motion_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | player_motion_ctrl                                                        |
// | Per-player motion/animation controller: turns held buttons into a step,   |
// | asks the arena collision checker, commits unblocked steps and walks the   |
// | animation frame. Optional macro: PLAYER_SPEED_BOOST_EN (speed_boost port).|
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module player_motion_ctrl #(
  parameter int START_X    = 32,
  parameter int START_Y    = 32,
  parameter int STEP       = 2,
  parameter int ANIM_TICKS = 8,
  parameter int X_MIN      = 32,
  parameter int X_MAX      = 576,
  parameter int Y_MIN      = 16,
  parameter int Y_MAX      = 416
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
`ifdef PLAYER_SPEED_BOOST_EN
  input  logic        speed_boost,
`endif
  output logic        chk_valid,
  output logic [10:0] chk_x,
  output logic [9:0]  chk_y,
  input  logic        chk_ready,
  input  logic        chk_blocked,
  output logic [10:0] sprite_x,
  output logic [9:0]  sprite_y,
  output logic [1:0]  dir,
  output logic [1:0]  walk_frame,
  output logic        moving
);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;
  localparam int         AW        = $clog2(ANIM_TICKS + 2);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_QUERY  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [10:0]     r_x, w_x_nxt, r_chk_x, w_chk_x_nxt;
  logic [9:0]      r_y, w_y_nxt, r_chk_y, w_chk_y_nxt;
  logic [1:0]      r_dir, w_dir_nxt, r_wf, w_wf_nxt;
  logic [AW-1:0]   r_anim, w_anim_nxt;
  logic            r_moving, w_moving_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_blocked, w_blocked_nxt;
  logic            r_boost, w_boost_nxt;

  logic            w_boost_in;
  logic [10:0]     w_step_x, w_cand_x;
  logic [9:0]      w_step_y, w_cand_y;
  logic [1:0]      w_dir_sel;
  logic            w_any_btn;
  logic            w_cand_moves;
  logic [AW-1:0]   w_inc, w_anim_sum;

`ifdef PLAYER_SPEED_BOOST_EN
  assign w_boost_in = speed_boost;
`else
  assign w_boost_in = 1'b0;
`endif

  assign w_step_x  = w_boost_in ? 11'(2 * STEP) : 11'(STEP);
  assign w_step_y  = w_boost_in ? 10'(2 * STEP) : 10'(STEP);
  assign w_any_btn = btn_up | btn_down | btn_left | btn_right;

  // Bound is compared before the subtraction so a step near zero never wraps.
  always_comb begin
    w_cand_x  = r_x;
    w_cand_y  = r_y;
    w_dir_sel = r_dir;
    if (btn_up) begin
      w_dir_sel = DIR_UP;
      w_cand_y  = (r_y < 10'(Y_MIN) + w_step_y) ? 10'(Y_MIN) : r_y - w_step_y;
    end else if (btn_down) begin
      w_dir_sel = DIR_DOWN;
      w_cand_y  = (r_y > 10'(Y_MAX) - w_step_y) ? 10'(Y_MAX) : r_y + w_step_y;
    end else if (btn_left) begin
      w_dir_sel = DIR_LEFT;
      w_cand_x  = (r_x < 11'(X_MIN) + w_step_x) ? 11'(X_MIN) : r_x - w_step_x;
    end else if (btn_right) begin
      w_dir_sel = DIR_RIGHT;
      w_cand_x  = (r_x > 11'(X_MAX) - w_step_x) ? 11'(X_MAX) : r_x + w_step_x;
    end
  end

  assign w_cand_moves = (w_cand_x != r_x) || (w_cand_y != r_y);
  assign w_inc        = r_boost ? AW'(2) : AW'(1);
  assign w_anim_sum   = r_anim + w_inc;

  always_comb begin
    w_state_nxt   = r_state;
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_chk_x_nxt   = r_chk_x;
    w_chk_y_nxt   = r_chk_y;
    w_dir_nxt     = r_dir;
    w_wf_nxt      = r_wf;
    w_anim_nxt    = r_anim;
    w_moving_nxt  = 1'b0;
    w_valid_nxt   = r_valid;
    w_blocked_nxt = r_blocked;
    w_boost_nxt   = r_boost;
    case (r_state)
      S_IDLE: begin
        if (tick) begin
          if (!w_any_btn) begin
            w_wf_nxt   = 2'd0;
            w_anim_nxt = '0;
          end else begin
            w_dir_nxt = w_dir_sel;
            if (w_cand_moves) begin
              w_chk_x_nxt = w_cand_x;
              w_chk_y_nxt = w_cand_y;
              w_valid_nxt = 1'b1;
              w_boost_nxt = w_boost_in;
              w_state_nxt = S_QUERY;
            end
          end
        end
      end
      S_QUERY: begin
        if (chk_ready) begin
          w_valid_nxt   = 1'b0;
          w_blocked_nxt = chk_blocked;
          w_state_nxt   = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (!r_blocked) begin
          w_x_nxt      = r_chk_x;
          w_y_nxt      = r_chk_y;
          w_moving_nxt = 1'b1;
          // Wrap keeps the remainder so a boosted step never skips a frame advance.
          if (w_anim_sum >= AW'(ANIM_TICKS)) begin
            w_anim_nxt = w_anim_sum - AW'(ANIM_TICKS);
            w_wf_nxt   = (r_wf == 2'd2) ? 2'd0 : r_wf + 2'd1;
          end else begin
            w_anim_nxt = w_anim_sum;
          end
        end
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_x       <= 11'(START_X);
      r_y       <= 10'(START_Y);
      r_chk_x   <= 11'(START_X);
      r_chk_y   <= 10'(START_Y);
      r_dir     <= DIR_DOWN;
      r_wf      <= 2'd0;
      r_anim    <= '0;
      r_moving  <= 1'b0;
      r_valid   <= 1'b0;
      r_blocked <= 1'b0;
      r_boost   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_x       <= w_x_nxt;
      r_y       <= w_y_nxt;
      r_chk_x   <= w_chk_x_nxt;
      r_chk_y   <= w_chk_y_nxt;
      r_dir     <= w_dir_nxt;
      r_wf      <= w_wf_nxt;
      r_anim    <= w_anim_nxt;
      r_moving  <= w_moving_nxt;
      r_valid   <= w_valid_nxt;
      r_blocked <= w_blocked_nxt;
      r_boost   <= w_boost_nxt;
    end
  end

  assign chk_valid  = r_valid;
  assign chk_x      = r_chk_x;
  assign chk_y      = r_chk_y;
  assign sprite_x   = r_x;
  assign sprite_y   = r_y;
  assign dir        = r_dir;
  assign walk_frame = r_wf;
  assign moving     = r_moving;

endmodule
`default_nettype wire

// File: tb/tb_player_motion_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_player_motion_ctrl                                                     |
// | Scoreboard bench: queries and commits are queued at stimulus time and     |
// | popped by a monitor when the DUT presents them. Rev 1.0                   |
// +--------------------------------------------------------------------------+
module tb_player_motion_ctrl;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic [1:0]  d;
    logic [1:0]  wf;
  } commit_t;

  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, tick2 = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic chk_ready = 1'b0, chk_blocked = 1'b0, chk_ready2 = 1'b0;

  logic        chk_valid, moving, chk_valid2, moving2;
  logic [10:0] chk_x, sprite_x, chk_x2, sprite_x2;
  logic [9:0]  chk_y, sprite_y, chk_y2, sprite_y2;
  logic [1:0]  dir, walk_frame, dir2, walk_frame2;

  int checks = 0;
  int errors = 0;

  logic [20:0] q_query[$];
  commit_t     q_commit[$];
  logic [20:0] m_q;
  commit_t     m_c;
  logic        prev_valid = 1'b0;
  logic [10:0] held_x = '0;
  logic [9:0]  held_y = '0;

  player_motion_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
`ifdef PLAYER_SPEED_BOOST_EN
    .speed_boost(1'b0),
`endif
    .chk_valid(chk_valid), .chk_x(chk_x), .chk_y(chk_y),
    .chk_ready(chk_ready), .chk_blocked(chk_blocked),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .dir(dir),
    .walk_frame(walk_frame), .moving(moving)
  );

  // Odd start column so a left step must clamp onto X_MIN.
  player_motion_ctrl #(.START_X(33)) u_dut_odd (
    .clk(clk), .rst_n(rst_n), .tick(tick2),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
`ifdef PLAYER_SPEED_BOOST_EN
    .speed_boost(1'b0),
`endif
    .chk_valid(chk_valid2), .chk_x(chk_x2), .chk_y(chk_y2),
    .chk_ready(chk_ready2), .chk_blocked(1'b0),
    .sprite_x(sprite_x2), .sprite_y(sprite_y2), .dir(dir2),
    .walk_frame(walk_frame2), .moving(moving2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_valid && !prev_valid) begin
        if (q_query.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_query: chk_valid rose with x=%0d y=%0d, none expected", chk_x, chk_y);
        end else begin
          m_q = q_query.pop_front();
          check("query_x", {21'd0, chk_x}, {21'd0, m_q[20:10]});
          check("query_y", {22'd0, chk_y}, {22'd0, m_q[9:0]});
        end
        held_x <= chk_x;
        held_y <= chk_y;
      end else if (chk_valid) begin
        check("query_stable_x", {21'd0, chk_x}, {21'd0, held_x});
        check("query_stable_y", {22'd0, chk_y}, {22'd0, held_y});
      end
      if (moving) begin
        if (q_commit.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_commit: moving high with sprite x=%0d y=%0d, none expected", sprite_x, sprite_y);
        end else begin
          m_c = q_commit.pop_front();
          check("commit_x", {21'd0, sprite_x}, {21'd0, m_c.x});
          check("commit_y", {22'd0, sprite_y}, {22'd0, m_c.y});
          check("commit_dir", {30'd0, dir}, {30'd0, m_c.d});
          check("commit_walk_frame", {30'd0, walk_frame}, {30'd0, m_c.wf});
        end
      end
    end
    prev_valid <= chk_valid;
  end

  // btns = {up, down, left, right}; ex/ey is the sprite position expected afterwards.
  task automatic move(input logic [3:0] btns, input logic blk, input logic expq,
                      input logic [10:0] qx, input logic [9:0] qy,
                      input logic [10:0] ex, input logic [9:0] ey,
                      input logic [1:0] edir, input logic [1:0] ewf);
    int n;
    @(negedge clk);
    {btn_up, btn_down, btn_left, btn_right} = btns;
    if (expq) q_query.push_back({qx, qy});
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    if (expq) begin
      n = 0;
      while (!chk_valid && n < 20) begin @(negedge clk); n++; end
      if (!chk_valid) begin
        checks++;
        errors++;
        $display("FAIL query_timeout: chk_valid=0 after %0d cycles, required 1", n);
        q_query.delete();
      end else begin
        repeat (2) @(negedge clk);
        chk_blocked = blk;
        chk_ready   = 1'b1;
        if (!blk) q_commit.push_back('{x: ex, y: ey, d: edir, wf: ewf});
        @(negedge clk);
        chk_ready   = 1'b0;
        chk_blocked = 1'b0;
        n = 0;
        while (q_commit.size() != 0 && n < 10) begin @(negedge clk); n++; end
        if (q_commit.size() != 0) begin
          checks++;
          errors++;
          $display("FAIL commit_timeout: moving never pulsed, required sprite x=%0d y=%0d", ex, ey);
          q_commit.delete();
        end
      end
    end
    repeat (4) @(negedge clk);
    check("dir", {30'd0, dir}, {30'd0, edir});
    check("walk_frame", {30'd0, walk_frame}, {30'd0, ewf});
    check("sprite_x", {21'd0, sprite_x}, {21'd0, ex});
    check("sprite_y", {22'd0, sprite_y}, {22'd0, ey});
    check("chk_valid_after", {31'd0, chk_valid}, 32'd0);
  endtask

  initial begin
    int n;
    logic seen;
    repeat (3) @(negedge clk);
    check("rst_sprite_x", {21'd0, sprite_x}, 32'd32);
    check("rst_sprite_y", {22'd0, sprite_y}, 32'd32);
    check("rst_dir", {30'd0, dir}, {30'd0, DIR_DOWN});
    check("rst_walk_frame", {30'd0, walk_frame}, 32'd0);
    check("rst_chk_valid", {31'd0, chk_valid}, 32'd0);
    check("rst_moving", {31'd0, moving}, 32'd0);
    check("rst_chk_x", {21'd0, chk_x}, 32'd32);
    check("rst_chk_y", {22'd0, chk_y}, 32'd32);
    check("rst_odd_sprite_x", {21'd0, sprite_x2}, 32'd33);
    rst_n = 1'b1;

    repeat (3) move(4'b0000, 1'b0, 1'b0, 11'd0, 10'd0, 11'd32, 10'd32, DIR_DOWN, 2'd0);

    // Response strobe with no query outstanding must be ignored.
    @(negedge clk); chk_ready = 1'b1;
    @(negedge clk); chk_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_ready_valid", {31'd0, chk_valid}, 32'd0);

    move(4'b0001, 1'b0, 1'b1, 11'd34, 10'd32, 11'd34, 10'd32, DIR_RIGHT, 2'd0);
    move(4'b0010, 1'b0, 1'b1, 11'd32, 10'd32, 11'd32, 10'd32, DIR_LEFT, 2'd0);
    move(4'b0010, 1'b0, 1'b0, 11'd0, 10'd0, 11'd32, 10'd32, DIR_LEFT, 2'd0);
    move(4'b1100, 1'b1, 1'b1, 11'd32, 10'd30, 11'd32, 10'd32, DIR_UP, 2'd0);
    move(4'b0011, 1'b0, 1'b0, 11'd0, 10'd0, 11'd32, 10'd32, DIR_LEFT, 2'd0);
    move(4'b0000, 1'b0, 1'b0, 11'd0, 10'd0, 11'd32, 10'd32, DIR_LEFT, 2'd0);

    for (int k = 1; k <= 40; k++)
      move(4'b0100, 1'b0, 1'b1, 11'd32, 10'(32 + 2 * k), 11'd32, 10'(32 + 2 * k),
           DIR_DOWN, 2'((k / 8) % 3));
    move(4'b0000, 1'b0, 1'b0, 11'd0, 10'd0, 11'd32, 10'd112, DIR_DOWN, 2'd0);

    // Second tick during an open query is dropped; then reset lands mid-query.
    @(negedge clk);
    btn_down = 1'b1;
    q_query.push_back({11'd32, 10'd114});
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0; btn_down = 1'b0;
    check("query_open", {31'd0, chk_valid}, 32'd1);
    btn_right = 1'b1; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0; btn_right = 1'b0;
    repeat (4) @(negedge clk);
    check("query_still_open", {31'd0, chk_valid}, 32'd1);
    check("dropped_tick_dir", {30'd0, dir}, {30'd0, DIR_DOWN});
    #2 rst_n = 1'b0;
    #1;
    check("midrst_chk_valid", {31'd0, chk_valid}, 32'd0);
    check("midrst_sprite_x", {21'd0, sprite_x}, 32'd32);
    check("midrst_sprite_y", {22'd0, sprite_y}, 32'd32);
    check("midrst_dir", {30'd0, dir}, {30'd0, DIR_DOWN});
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    move(4'b0001, 1'b0, 1'b1, 11'd34, 10'd32, 11'd34, 10'd32, DIR_RIGHT, 2'd0);

    // Clamp onto X_MIN from an odd column, then no query at the bound.
    @(negedge clk);
    btn_left = 1'b1; tick2 = 1'b1;
    @(negedge clk);
    tick2 = 1'b0; btn_left = 1'b0;
    n = 0;
    while (!chk_valid2 && n < 20) begin @(negedge clk); n++; end
    check("odd_query_valid", {31'd0, chk_valid2}, 32'd1);
    check("odd_query_x", {21'd0, chk_x2}, 32'd32);
    check("odd_query_y", {22'd0, chk_y2}, 32'd32);
    @(negedge clk); chk_ready2 = 1'b1;
    @(negedge clk); chk_ready2 = 1'b0;
    n = 0;
    while (!moving2 && n < 10) begin @(negedge clk); n++; end
    check("odd_commit_moving", {31'd0, moving2}, 32'd1);
    check("odd_commit_x", {21'd0, sprite_x2}, 32'd32);
    @(negedge clk);
    btn_left = 1'b1; tick2 = 1'b1;
    @(negedge clk);
    tick2 = 1'b0; btn_left = 1'b0;
    seen = 1'b0;
    repeat (6) begin seen = seen | chk_valid2; @(negedge clk); end
    check("odd_bound_no_query", {31'd0, seen}, 32'd0);
    check("odd_bound_dir", {30'd0, dir2}, {30'd0, DIR_LEFT});
    check("odd_bound_x", {21'd0, sprite_x2}, 32'd32);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
